// File: rtl/dff_pkg.sv
// Shared constants for the dff_pipe register pipeline.
//   DFF_WIDTH     : default data width in bits
//   DFF_DEPTH     : default number of register stages
//   DFF_RESET_VAL : default data value loaded on reset (truncated to WIDTH)
//   DFF_MAX_*     : supported parameter limits
package dff_pkg;

  localparam int unsigned DFF_WIDTH     = 8;
  localparam int unsigned DFF_DEPTH     = 4;
  localparam int unsigned DFF_MAX_WIDTH = 64;
  localparam int unsigned DFF_MAX_DEPTH = 16;

  localparam logic [DFF_MAX_WIDTH-1:0] DFF_RESET_VAL = '0;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// One pipeline stage: a valid flag plus a data register with load enable.
//   clk, reset : clock and asynchronous active-low reset
//   flush      : synchronous clear of the valid flag (data left untouched)
//   load       : an item enters this stage on the next edge (loads din)
//   drain      : the held item leaves this stage on the next edge
//   din        : incoming data
//   valid      : stage holds an item
//   dout       : stage data
module dff_stage
  import dff_pkg::*;
#(
  parameter int unsigned            WIDTH     = DFF_WIDTH,
  parameter logic [WIDTH-1:0]       RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] dout
);

  // Valid: flush wins; a load while draining keeps the stage occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // Data only changes on a real load, so a stalled stage holds its item.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout <= RESET_VAL;
    end else if (load && !flush) begin
      dout <= din;
    end
  end

endmodule : dff_stage

// File: rtl/dff_pipe.sv
// Valid/ready register pipeline of DEPTH stages with bubble collapsing.
//   clk, reset          : clock and asynchronous active-low reset
//   flush               : clear every stage valid on the next edge
//   in_valid/in_ready   : upstream handshake, in_data accepted when both high
//   out_valid/out_ready : downstream handshake on the last stage
//   out_data            : data of the last stage
//   occupancy           : number of valid stages (0..DEPTH)
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DFF_WIDTH,
  parameter int unsigned      DEPTH     = DFF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept;
  logic [OCC_W-1:0] occ_c;

  // Advance chain, evaluated from the output end back toward the input so
  // every stage sees whether its successor frees up this cycle.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v[DEPTH-1] & out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = v[i] & (~v[i+1] | adv[i+1]);
    end
  end

  assign in_ready  = ~flush & (~v[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];

  // Stage 0 loads from the input port, later stages from their predecessor.
  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    logic             stage_load;
    logic [WIDTH-1:0] stage_din;

    if (g == 0) begin : g_first
      assign stage_load = accept;
      assign stage_din  = in_data;
    end else begin : g_next
      assign stage_load = adv[g-1];
      assign stage_din  = d[g-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (stage_load),
      .drain (adv[g]),
      .din   (stage_din),
      .valid (v[g]),
      .dout  (d[g])
    );
  end

  // Population count of the valid flags.
  always_comb begin
    occ_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_c = occ_c + OCC_W'(v[i]);
    end
  end

  assign occupancy = occ_c;

endmodule : dff_pipe
